// File: rtl/alu_selftest.sv
// Built-in self-test driver/checker for the execute-stage ALU: LFSR vectors out, result/zero checked against a model.
// Build option: define ALU_SELFTEST_SLT_EN to add signed set-less-than (opcode 101) to the opcode rotation.
module alu_selftest #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE12B3D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
`ifdef ALU_SELFTEST_SLT_EN
  localparam logic [2:0]  LAST_OP   = 3'd4;
`else
  localparam logic [2:0]  LAST_OP   = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t      state, state_next;
  logic        load_first, load_next;
  logic [31:0] lfsr, lfsr_b, seed_b;
  logic [15:0] vec_idx;
  logic [2:0]  op_idx, op_idx_next;
  logic [31:0] res_q;
  logic        zero_q;
  logic [31:0] exp_res;
  logic        exp_zero, mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  function automatic logic [2:0] op_at(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b011;
`ifdef ALU_SELFTEST_SLT_EN
      default: return 3'b101;
`else
      default: return 3'b000;
`endif
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
`ifdef ALU_SELFTEST_SLT_EN
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
`endif
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
`ifdef ALU_SELFTEST_SLT_EN
      3'b101:  return {31'b0, (sa < sb)};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = APPLY;
          load_first = 1'b1;
        end
      end
      APPLY: state_next = CHECK;
      CHECK: begin
        if (vec_idx < LAST_IDX) begin
          state_next = APPLY;
          load_next  = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state == APPLY) || (state == CHECK);
  assign done        = (state == DONE);
  assign pass        = done && (err_count == 16'h0);
  assign seed_b      = lfsr_step(SEED);
  assign lfsr_b      = lfsr_step(lfsr);
  assign op_idx_next = (op_idx == LAST_OP) ? 3'd0 : op_idx + 3'd1;

  // Vector issue: operands and opcode held for the APPLY/CHECK pair of each vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src_a   <= 32'h0;
      alu_src_b   <= 32'h0;
      alu_control <= 3'b000;
      vec_idx     <= 16'h0;
      op_idx      <= 3'd0;
    end else if (load_first) begin
      alu_src_a   <= SEED;
      alu_src_b   <= seed_b;
      alu_control <= op_at(3'd0);
      vec_idx     <= 16'h0;
      op_idx      <= 3'd0;
    end else if (load_next) begin
      alu_src_a   <= lfsr;
      alu_src_b   <= lfsr_b;
      alu_control <= op_at(op_idx_next);
      vec_idx     <= vec_idx + 16'd1;
      op_idx      <= op_idx_next;
    end
  end

  // Datapath-only registers: LFSR runs two steps ahead of the issued operands; ALU response capture
  always_ff @(posedge clk) begin
    if (load_first)     lfsr <= lfsr_step(seed_b);
    else if (load_next) lfsr <= lfsr_step(lfsr_b);
    if (state == APPLY) begin
      res_q  <= alu_result;
      zero_q <= alu_zero;
    end
  end

  assign exp_res  = ref_alu(alu_src_a, alu_src_b, alu_control);
  assign exp_zero = (exp_res == 32'h0);
  assign mismatch = (state == CHECK) && ((res_q != exp_res) || (zero_q != exp_zero));

  // Check stage: error accounting at the end of CHECK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= 16'h0;
      first_fail_idx <= 16'hFFFF;
    end else if (load_first) begin
      err_count      <= 16'h0;
      first_fail_idx <= 16'hFFFF;
    end else if (mismatch) begin
      err_count <= sat_inc(err_count);
      if (first_fail_idx == 16'hFFFF) first_fail_idx <= vec_idx;
    end
  end

endmodule

// File: tb/tb_alu_selftest.sv
// Scoreboard bench for alu_selftest: a behavioural ALU with selectable faults drives the DUT;
// expected vectors and run summaries are queued by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_alu_selftest;

  localparam int          N    = 10;
  localparam logic [31:0] SEED = 32'hACE12B3D;
`ifdef ALU_SELFTEST_SLT_EN
  localparam int          NOPS = 5;
`else
  localparam int          NOPS = 4;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } vec_t;

  typedef struct {
    int err;
    int ffi;
    int done_cyc;
  } sum_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero, busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  int   fault_mode = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t vec_q[$];
  sum_t sum_q[$];

  alu_selftest #(.NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [2:0] op_seq(input int k);
    logic [2:0] ops [5];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    return ops[k % NOPS];
  endfunction

  // Correct ALU behaviour
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // ALU as seen by the DUT, with an optional planted fault
  function automatic logic [31:0] bench_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op, input int fm);
    if (fm == 1 && op == 3'b001) return a + b;
    if (fm == 2 && op == 3'b101) return 32'h0;
    return ref_alu(a, b, op);
  endfunction

  always_comb begin
    alu_result = bench_alu(alu_src_a, alu_src_b, alu_control, fault_mode);
    alu_zero   = (fault_mode == 3) ? 1'b1 : (alu_result == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    chk({tag, "_first_fail_idx"}, 32'(first_fail_idx), 32'hFFFF);
    chk({tag, "_alu_control"}, 32'(alu_control), 32'h0);
    chk({tag, "_src_a"}, alu_src_a, 32'h0);
    chk({tag, "_src_b"}, alu_src_b, 32'h0);
  endtask

  // Queue the expected run, then pulse start for one cycle (returns at the negedge after the sampling edge)
  task automatic issue(input int fm, output sum_t s);
    logic [31:0] l, a, b, r, good;
    logic        z;
    vec_t        v;
    fault_mode = fm;
    @(negedge clk);
    l = SEED;
    s.err = 0;
    s.ffi = 16'hFFFF;
    for (int k = 0; k < N; k++) begin
      a = l;
      b = step(a);
      l = step(b);
      v.a = a; v.b = b; v.op = op_seq(k);
      vec_q.push_back(v);
      good = ref_alu(a, b, v.op);
      r    = bench_alu(a, b, v.op, fm);
      z    = (fm == 3) ? 1'b1 : (r == 32'h0);
      if (r != good || z != (good == 32'h0)) begin
        s.err++;
        if (s.ffi == 16'hFFFF) s.ffi = k;
      end
    end
    s.done_cyc = cyc + 1 + 2 * N;
    sum_q.push_back(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input sum_t s);
    bit got = 0;
    for (int i = 0; i < 2 * N + 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'h1);
    if (!got) begin
      vec_q.delete();
      sum_q.delete();
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 32'h1);
    chk({tag, "_pass_held"}, 32'(pass), (s.err == 0) ? 32'h1 : 32'h0);
  endtask

  task automatic run(input string tag, input int fm, input bit poke_start);
    sum_t s;
    issue(fm, s);
    if (poke_start) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(tag, s);
  endtask

  // Monitor: compares each presented vector and each completed run against the queues
  initial begin
    int   phase = 0;
    bit   done_prev = 0;
    vec_t v;
    sum_t s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        phase = 0;
        done_prev = 0;
      end else begin
        if (busy) begin
          if (phase == 0) begin
            if (vec_q.size() == 0) begin
              chk("vec_underflow", 32'h1, 32'h0);
            end else begin
              v = vec_q.pop_front();
              chk("src_a", alu_src_a, v.a);
              chk("src_b", alu_src_b, v.b);
              chk("alu_control", 32'(alu_control), 32'(v.op));
            end
          end
          phase ^= 1;
        end else begin
          phase = 0;
        end
        if (done && !done_prev) begin
          if (sum_q.size() == 0) begin
            chk("sum_underflow", 32'h1, 32'h0);
          end else begin
            s = sum_q.pop_front();
            chk("err_count", 32'(err_count), 32'(s.err));
            chk("first_fail_idx", 32'(first_fail_idx), 32'(s.ffi));
            chk("pass", 32'(pass), (s.err == 0) ? 32'h1 : 32'h0);
            chk("done_cycle", 32'(cyc), 32'(s.done_cyc));
            chk("busy_at_done", 32'(busy), 32'h0);
          end
        end
        done_prev = done;
      end
    end
  end

  initial begin
    sum_t s;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    run("good", 0, 1'b1);
    run("sub_fault", 1, 1'b0);
    run("zero_stuck", 3, 1'b0);

    // Reset asserted asynchronously while vector 3 is applied
    issue(0, s);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset("midrun");
    vec_q.delete();
    sum_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    run("rerun", 0, 1'b0);
    run("slt_fault", 2, 1'b0);

    chk("queues_drained", 32'(vec_q.size() + sum_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
